// File: rtl/icg_ctrl_pkg.sv
// Shared types and constants for the idle clock-gating controller.
package icg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_WAKE = 2'b01,
        ST_ON   = 2'b10
    } clk_state_e;

    localparam int GATE_CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [GATE_CNT_W-1:0] sat_inc_gate(input logic [GATE_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/icg_idle_ctrl_if.sv
// Request/ack/busy bundle between the requesting units and the controller.
interface icg_idle_ctrl_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req_vld;
    logic [NUM_REQ-1:0] req_ack;
    logic [NUM_REQ-1:0] busy;

    modport master (output req_vld, output busy, input req_ack);
    modport slave  (input req_vld, input busy, output req_ack);
endinterface

// File: rtl/icg_idle_timer.sv
// Saturating idle-cycle counter with a >= threshold compare.
// Hold wins over clear, clear wins over increment.
module icg_idle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_hold,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic [W-1:0] i_thresh,
    output logic         o_reached
);
    logic [W-1:0] r_cnt;

    // Count consecutive idle cycles, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_hold) begin
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_inc && !(&r_cnt)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // >= rather than == so a threshold lowered mid-count still gates.
    assign o_reached = (r_cnt >= i_thresh);

endmodule

// File: rtl/icg_idle_ctrl.sv
// Clock-gating sequencer: wakes the gated clock on request, acks units once
// the clock is stable, and gates it again after a run of idle cycles.
module icg_idle_ctrl
    import icg_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int IDLE_CNT_W = 4,
    parameter int WAKE_LAT   = 1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    icg_idle_ctrl_if.slave        req_if,
    input  logic [IDLE_CNT_W-1:0] idle_thresh,
    input  logic                  pad_yy_icg_scan_en,
    output logic                  icg_local_en,
    output logic [1:0]            clk_state,
    output logic [GATE_CNT_W-1:0] gate_cnt
);
    localparam logic [2:0] WAKE_LAST = 3'(WAKE_LAT - 1);

    clk_state_e            r_state;
    clk_state_e            w_state_nxt;
    logic [2:0]            r_wake_cnt;
    logic [NUM_REQ-1:0]    r_req_ack;
    logic [NUM_REQ-1:0]    w_ack_nxt;
    logic                  r_local_en;
    logic                  w_en_nxt;
    logic [GATE_CNT_W-1:0] r_gate_cnt;
    logic                  w_idle;
    logic                  w_idle_reached;
    logic                  w_gate;
    logic                  w_idle_clr;

    assign w_idle = ~|req_if.req_vld & ~|req_if.busy & ~|r_req_ack;
    assign w_gate = (r_state == ST_ON) & w_idle & w_idle_reached;

    // State register; scan freezes the sequencer where it is.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_state <= ST_OFF;
        end else if (!pad_yy_icg_scan_en) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF:  if (|req_if.req_vld) w_state_nxt = ST_WAKE;
            ST_WAKE: if (r_wake_cnt == WAKE_LAST) w_state_nxt = ST_ON;
            ST_ON:   if (w_gate) w_state_nxt = ST_OFF;
            default: w_state_nxt = ST_OFF;
        endcase
    end

    // Next values of the registered outputs and idle-timer controls.
    always_comb begin
        w_en_nxt   = (w_state_nxt != ST_OFF);
        w_ack_nxt  = '0;
        w_idle_clr = (r_state != ST_ON) | ~w_idle | w_gate;
        if ((r_state == ST_ON) && !pad_yy_icg_scan_en) begin
            w_ack_nxt = req_if.req_vld & ~r_req_ack;
        end
    end

    // Wake settle counter; parked at zero while OFF so each wake starts fresh.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_wake_cnt <= '0;
        end else if (!pad_yy_icg_scan_en) begin
            if (r_state == ST_OFF) begin
                r_wake_cnt <= '0;
            end else if (r_state == ST_WAKE) begin
                r_wake_cnt <= r_wake_cnt + 3'd1;
            end
        end
    end

    // Registered enable, acks and gating-event counter.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_local_en <= 1'b0;
            r_req_ack  <= '0;
            r_gate_cnt <= '0;
        end else begin
            r_req_ack <= w_ack_nxt;
            if (!pad_yy_icg_scan_en) begin
                r_local_en <= w_en_nxt;
                if (w_gate) begin
                    r_gate_cnt <= sat_inc_gate(r_gate_cnt);
                end
            end
        end
    end

    icg_idle_timer #(
        .W (IDLE_CNT_W)
    ) u_idle_timer (
        .clk       (forever_cpuclk),
        .rst       (cpurst),
        .i_hold    (pad_yy_icg_scan_en),
        .i_clr     (w_idle_clr),
        .i_inc     (w_idle),
        .i_thresh  (idle_thresh),
        .o_reached (w_idle_reached)
    );

    assign icg_local_en   = r_local_en | pad_yy_icg_scan_en;
    assign clk_state      = r_state;
    assign req_if.req_ack = r_req_ack;
    assign gate_cnt       = r_gate_cnt;

endmodule
